// File: rtl/hack_serial_pkg.sv
// Shared definitions for the serial transmit blocks.
//   ser_state_e       : transmitter FSM state (IDLE, SHIFT)
//   SER_WIDTH_DEFAULT : default parallel word length in bits
package hack_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int unsigned SER_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/serializer_16.sv
// Parallel-to-serial transmitter, MSB first, with valid/ready intake and abort.
// Ports:
//   clk      : clock, all state updates on rising edge
//   reset    : asynchronous active-high reset
//   data_i   : parallel word to transmit (sampled only on acceptance)
//   valid_i  : data_i is valid
//   ready_o  : word accepted this cycle if valid_i is also high
//   abort_i  : synchronous flush of the word in flight
//   ser_o    : serial data bit
//   ser_en_o : ser_o valid this cycle
//   last_o   : final bit of the current word
//   busy_o   : a word is being shifted out
module serializer_16
  import hack_serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             abort_i,
  output logic             ser_o,
  output logic             ser_en_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_shift;
  logic             last_bit;
  logic             accept;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == CntLast);
  // Ready on the last bit as well, so a new word follows without a gap.
  assign ready_o  = !abort_i && (!in_shift || last_bit);
  assign accept   = valid_i && ready_o;

  // Serial outputs come only from registered state.
  assign ser_o    = in_shift && shift_q[WIDTH-1];
  assign ser_en_o = in_shift;
  assign last_o   = last_bit;
  assign busy_o   = in_shift;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SHIFT;
            shift_d = data_i;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (accept) begin
            shift_d = data_i;
            cnt_d   = '0;
          end else if (last_bit) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/serializer_16.md
SERIALIZER_16 -- requirements
Module: serializer_16

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: word length in bits, legal range 2..32.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL provide port data_i, input, WIDTH: parallel word to transmit.
REQ-005 SHALL provide port valid_i, input, 1: data_i is valid.
REQ-006 SHALL provide port ready_o, output, 1: block accepts data_i this cycle.
REQ-007 SHALL provide port abort_i, input, 1: synchronous flush of the word in flight.
REQ-008 SHALL provide port ser_o, output, 1: serial data, MSB first.
REQ-009 SHALL provide port ser_en_o, output, 1: ser_o valid this cycle; drives the en_i of a downstream 16-bit serial-in shift register.
REQ-010 SHALL provide port last_o, output, 1: high with the final bit of each word.
REQ-011 SHALL provide port busy_o, output, 1: high while state is SHIFT.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SHIFT, with a shift register shift_q[WIDTH-1:0] and a bit counter cnt_q of width clog2(WIDTH).
REQ-013 Handshake: a word SHALL be accepted on a rising edge where valid_i and ready_o are both high.
REQ-014 In IDLE, ready_o SHALL be 1 and ser_o, ser_en_o, last_o and busy_o SHALL be 0.
REQ-015 On acceptance, the block SHALL load shift_q with data_i, set cnt_q to 0, and move to SHIFT.
REQ-016 In SHIFT:
- ser_o SHALL equal shift_q[WIDTH-1] and ser_en_o SHALL be 1.
- On each edge, shift_q SHALL shift left by one with 0 filled in, and cnt_q SHALL increment by 1.
REQ-017 Latency: the first bit SHALL appear on ser_o in the cycle after the acceptance edge, and the word SHALL occupy exactly WIDTH consecutive ser_en_o cycles.
REQ-018 last_o SHALL be 1 only when state is SHIFT and cnt_q equals WIDTH-1.
REQ-019 ready_o SHALL be 1 in SHIFT only when last_o is 1, which allows back-to-back acceptance.
REQ-020 Last bit with a word accepted: the block SHALL reload shift_q, reset cnt_q to 0, and stay in SHIFT, so ser_en_o has no gap between words.
REQ-021 Last bit with no word accepted: the block SHALL return to IDLE on the next edge.
REQ-022 When abort_i is 1, ready_o SHALL be 0, and on the edge the state SHALL go to IDLE with shift_q and cnt_q cleared.
REQ-023 abort_i SHALL take precedence over acceptance and shifting in the same cycle.
REQ-024 abort_i in IDLE SHALL have no effect other than masking ready_o.
REQ-025 data_i SHALL be sampled only on the acceptance edge; changes on data_i at any other time SHALL not affect the word in flight.
REQ-026 cnt_q SHALL never exceed WIDTH-1, with no wrap-around beyond the last bit.

Reset
REQ-027 When reset is 1, the block SHALL immediately force state IDLE, shift_q 0 and cnt_q 0, independent of clk.
REQ-028 During reset, outputs SHALL read ready_o 1, ser_o 0, ser_en_o 0, last_o 0 and busy_o 0.
REQ-029 Reset asserted mid-word SHALL discard the word, with no further ser_en_o pulses after reset is released until a new acceptance.

Structure
REQ-030 Shared package hack_serial_pkg SHALL hold the state typedef (IDLE, SHIFT) and the constant SER_WIDTH_DEFAULT = 16.
REQ-031 Counter, FSM and shift register SHALL be coded inline; no sub-module is natural and none SHALL be created.
REQ-032 All outputs SHALL be derived from registered state only, with no combinational path from valid_i or data_i to ser_o or ser_en_o.

Verification
REQ-033 Single word 0xA5C3 -> ser_o = 1010010111000011 over 16 consecutive ser_en_o cycles, last_o on the 16th; a downstream 16-bit shift register then holds 0xA5C3.
REQ-034 Back-to-back: 0xFFFF, then 0x0001 presented with valid_i during last_o -> 32 gapless ser_en_o cycles; downstream register reads 0xFFFF after cycle 16 and 0x0001 after cycle 32.
REQ-035 Abort: abort_i at bit 5 of 0x1234 -> ser_en_o 0 from the next cycle, busy_o 0, ready_o 1; the next word 0x00FF transmits correctly.
REQ-036 Simultaneous: valid_i=1 with data 0xBEEF and abort_i=1 in IDLE -> not accepted and no ser_en_o; valid_i held one more cycle with abort_i=0 -> accepted.
REQ-037 Reset mid-word: reset pulse asynchronous to clk at bit 9 -> outputs at reset values immediately and no ser_en_o until a new acceptance.
REQ-038 data_i toggled every cycle during SHIFT -> transmitted bits match only the word sampled at acceptance.
